// File: rtl/piece_bag_generator_pkg.sv
// Shared piece codes, bag constants and small helpers for the 7-bag piece generator.
package tetris_pkg;

  localparam int unsigned NUM_PIECES = 7;
  localparam int unsigned PIECE_W    = 3;
  localparam logic [3:0]  REJ_LIMIT  = 4'd8;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } bag_state_e;

  function automatic piece_t lowest_set(input logic [NUM_PIECES-1:0] m);
    piece_t r;
    r = PIECE_I;
    for (int unsigned i = NUM_PIECES; i > 0; i--) begin
      if (m[i-1]) r = piece_t'(PIECE_W'(i-1));
    end
    return r;
  endfunction

  function automatic logic [PIECE_W-1:0] popcount7(input logic [NUM_PIECES-1:0] m);
    logic [PIECE_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_PIECES; i++) begin
      n = n + {{(PIECE_W-1){1'b0}}, m[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/piece_bag_generator_lfsr.sv
// Right-shifting Galois LFSR with loadable state; an all-zero seed or load value becomes 1.
module lfsr_galois #(
  parameter int unsigned     W    = 16,
  parameter logic [W-1:0]    TAPS = 16'hB400,
  parameter logic [W-1:0]    SEED = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] ONE        = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] RESET_VAL  = (SEED == '0) ? ONE : SEED;

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    if (load) begin
      state_d = (load_val == '0) ? ONE : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag Tetris piece generator with a PREVIEW+1 deep lookahead queue and pop handshake.
module piece_bag_generator #(
  parameter int unsigned           LFSR_W  = 16,
  parameter logic [LFSR_W-1:0]     TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0]     SEED    = 16'hACE1,
  parameter int unsigned           PREVIEW = 3
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    take,
  input  logic                    reseed,
  input  logic [LFSR_W-1:0]       seed,
  output logic                    ready,
  output logic [2:0]              piece,
  output logic [3*PREVIEW-1:0]    preview,
  output logic [2:0]              bag_count
);

  import tetris_pkg::*;

  localparam int unsigned DEPTH = PREVIEW + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [NUM_PIECES-1:0] MASK_ONE = {{(NUM_PIECES-1){1'b0}}, 1'b1};

  bag_state_e             state_q, state_d;
  logic [NUM_PIECES-1:0]  mask_q, mask_d;
  logic [3:0]             rej_q, rej_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PIECE_W-1:0]     bag_count_q, bag_count_d;
  piece_t                 queue_q [DEPTH];
  piece_t                 queue_d [DEPTH];

  logic [LFSR_W-1:0]      lfsr;
  logic [PIECE_W-1:0]     cand;
  logic [NUM_PIECES:0]    avail;
  logic                   pop, draw_en, hit, forced, accept;
  piece_t                 pick;
  logic                   unused_lfsr_hi;

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .nreset   (nreset),
    .load     (reseed),
    .load_val (seed),
    .state    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:PIECE_W];

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rej_d   = rej_q;
    count_d = count_q;
    queue_d = queue_q;

    cand    = lfsr[PIECE_W-1:0];
    avail   = {1'b0, mask_q};
    pop     = take && (state_q == ST_FULL);
    draw_en = (state_q == ST_FILL) || pop;
    hit     = avail[cand];
    forced  = (rej_q == REJ_LIMIT);
    accept  = draw_en && (hit || forced);
    pick    = hit ? piece_t'(cand) : lowest_set(mask_q);

    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        queue_d[i] = queue_q[i+1];
      end
      queue_d[DEPTH-1] = PIECE_I;
      count_d = count_q - CNT_W'(1);
    end

    // The tail slot is taken after any pop shift, so a simultaneous pop+draw lands in DEPTH-1.
    if (accept) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (count_d == CNT_W'(i)) queue_d[i] = pick;
      end
      count_d = count_d + CNT_W'(1);
      mask_d  = mask_q & ~(MASK_ONE << pick);
      if (mask_d == '0) mask_d = '1;
      rej_d   = '0;
    end else if (draw_en) begin
      rej_d = rej_q + 4'd1;
    end

    state_d = (count_d == CNT_W'(DEPTH)) ? ST_FULL : ST_FILL;

    if (reseed) begin
      state_d = ST_FILL;
      mask_d  = '1;
      rej_d   = '0;
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        queue_d[i] = PIECE_I;
      end
    end

    bag_count_d = popcount7(mask_d);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_FILL;
      mask_q      <= '1;
      rej_q       <= '0;
      count_q     <= '0;
      bag_count_q <= 3'd7;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        queue_q[i] <= PIECE_I;
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      rej_q       <= rej_d;
      count_q     <= count_d;
      bag_count_q <= bag_count_d;
      queue_q     <= queue_d;
    end
  end

  assign ready     = (state_q == ST_FULL);
  assign piece     = queue_q[0];
  assign bag_count = bag_count_q;

  always_comb begin
    preview = '0;
    for (int unsigned k = 0; k < PREVIEW; k++) begin
      preview[PIECE_W*k +: PIECE_W] = queue_q[k+1];
    end
  end

endmodule
